if_id_queue: RTL and testbench
==============================

Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register: a DEPTH-entry FIFO between the fetch unit and the decoder.
- Decouples fetch from decode stalls with a valid/ready handshake on both sides.
- Each entry carries pc, instruction, predicted next_pc, next_taken and branch_slot_end.
- Redirect or flush empties the queue in one cycle; an empty queue presents a NOP to the decoder.

Parameters:
- DEPTH, 4, number of entries; power of two, 2..16.
- ADDR_W, 32, width of pc and next_pc.
- INST_W, 32, instruction width.
- NOP_VAL, 32'h0000_0013, instruction presented when the queue is empty (addi x0,x0,0).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- flush_i  in  1  pipeline flush from ctrl
- branch_redirect_i  in  1  mispredict redirect from exu
- if_valid_i  in  1  fetch presents an entry
- if_ready_o  out  1  queue accepts an entry (not full)
- pc_i  in  ADDR_W  fetched pc
- ins_i  in  INST_W  fetched instruction
- next_pc_i  in  ADDR_W  predicted next pc
- next_taken_i  in  1  prediction taken
- branch_slot_end_i  in  1  branch slot end marker
- id_valid_o  out  1  head entry valid
- id_ready_i  in  1  decoder consumes head this cycle
- pc_o  out  ADDR_W  head pc
- ins_o  out  INST_W  head instruction, NOP_VAL when empty
- next_pc_o  out  ADDR_W  head next_pc
- next_taken_o  out  1  head next_taken
- branch_slot_end_o  out  1  head marker; 0 when empty
- count_o  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Clocking and reset: one clock clk_i; rst_i is synchronous and active-high.
- Storage and pointers: circular buffer with wr_ptr, rd_ptr and count registers.
- Reset values: pointers and count = 0; storage contents don't-care.
- Outputs after reset: id_valid_o=0, ins_o=NOP_VAL, pc_o=0, next_pc_o=0, next_taken_o=0, branch_slot_end_o=0, if_ready_o=1, count_o=0.
- Push = if_valid_i && if_ready_o. It writes storage[wr_ptr] and increments wr_ptr modulo DEPTH.
- Pop = id_valid_o && id_ready_i. It increments rd_ptr modulo DEPTH.
- if_ready_o = (count != DEPTH). It is combinational from count only and does not depend on id_ready_i, so a full queue refuses a push even while popping.
- id_valid_o = (count != 0), except when bypass is enabled (see Optional Feature).
- Head outputs are driven combinationally from storage[rd_ptr] and gated when empty: ins_o=NOP_VAL and branch_slot_end_o=0. pc_o, next_pc_o and next_taken_o hold the stale head value and are ignored by the decoder.
- Latency: an entry pushed at edge N is visible at the head after edge N when the queue was empty.
- Count update: push only → +1; pop only → −1; push and pop together → unchanged; both pointers advance.
- Flush (flush_i or branch_redirect_i high):
  - next edge sets count=0 and rd_ptr=wr_ptr=0;
  - any push or pop in that cycle is discarded;
  - both flush inputs have equal effect and are OR-ed.
- Priority at each edge: rst_i > flush > push/pop.
- Wrap-around: pointers wrap silently; DEPTH being a power of two makes the wrap a natural overflow.
- Overflow and underflow are impossible by construction. Assertions (simulation only) check that count never exceeds DEPTH and that no pop occurs when count==0.

Optional Feature:
- Macro: IF_ID_QUEUE_BYPASS_EN.
- Defined: when count==0 and if_valid_i=1, the fetch inputs drive the head outputs combinationally and id_valid_o=1.
  - If id_ready_i=1 in that cycle, the entry is consumed without being written; count stays 0.
  - If id_ready_i=0, the entry is written normally.
  - Gives zero-cycle latency through an empty queue.
- Undefined: no bypass; minimum latency is one cycle and there is no combinational path from the if_* inputs to the id_* outputs.

Decomposition:
- Shared package/defines: NOP_VAL (the existing NOP_INST define), ADDR_W/INST_W defaults, and a packed entry layout {pc, ins, next_pc, next_taken, branch_slot_end} with its width constant.
- One natural sub-module: if_id_queue_mem, a DEPTH x entry-width register array with one write port and one async read port, no reset.
- Pointer, count and flush logic stay in the top module.

Test Plan:
- Reset, then idle → id_valid_o=0, ins_o=32'h00000013, if_ready_o=1, count_o=0.
- Push pc 0x100/0x104/0x108 with ins 0xA/0xB/0xC while id_ready_i=0; then id_ready_i=1 → decoder sees 0x100/A, 0x104/B, 0x108/C in order; count_o goes 3,2,1,0.
- Push 4 entries with id_ready_i=0 (DEPTH=4) → if_ready_o=0 and a 5th if_valid_i is not accepted. Pop one → if_ready_o=1; a later push wraps wr_ptr to 0 and FIFO order is preserved across the wrap.
- Continuous push and pop with 2 entries resident for 20 cycles → count_o stays 2 and all 20 pcs emerge in order.
- Queue holding 3 entries; assert branch_redirect_i for one cycle together with if_valid_i=1 → next cycle count_o=0, id_valid_o=0, ins_o=NOP. Repeat with flush_i → same result. Repeat with rst_i and flush_i together → reset values.
- IF_ID_QUEUE_BYPASS_EN defined, queue empty, if_valid_i=1, pc 0x200, id_ready_i=1 → same cycle id_valid_o=1 and pc_o=0x200; count_o stays 0. Without the macro → id_valid_o=1 one cycle later.

Source files
------------

// File: rtl/if_id_queue_pkg.sv
// Shared definitions for the IF/ID instruction queue: default widths, NOP encoding, entry layout.
package if_id_queue_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned INST_W_DEF = 32;

    // addi x0,x0,0 presented to the decoder when nothing is queued
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Entry layout at the default widths; the top packs the same field order for any width
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] pc;
        logic [INST_W_DEF-1:0] ins;
        logic [ADDR_W_DEF-1:0] next_pc;
        logic                  next_taken;
        logic                  branch_slot_end;
    } if_id_entry_t;

    localparam int unsigned ENTRY_W = $bits(if_id_entry_t);

    // Width of one packed entry {pc, ins, next_pc, next_taken, branch_slot_end}
    function automatic int unsigned entry_width(input int unsigned addr_w, input int unsigned inst_w);
        return 2 * addr_w + inst_w + 2;
    endfunction

endpackage

// File: rtl/if_id_queue_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port, no reset.
module if_id_queue_mem #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port; contents are don't-care until written
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: DEPTH-entry FIFO between fetch and decode with valid/ready on both sides.
// Flush or branch redirect empties it in one cycle; an empty queue presents a NOP to the decoder.
// Optional: define IF_ID_QUEUE_BYPASS_EN for a zero-latency path from fetch through an empty queue.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int unsigned       DEPTH   = 4,
    parameter int unsigned       ADDR_W  = ADDR_W_DEF,
    parameter int unsigned       INST_W  = INST_W_DEF,
    parameter logic [INST_W-1:0] NOP_VAL = INST_W'(NOP_INST),
    localparam int unsigned      CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              branch_redirect_i,
    input  logic              if_valid_i,
    output logic              if_ready_o,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [INST_W-1:0] ins_i,
    input  logic [ADDR_W-1:0] next_pc_i,
    input  logic              next_taken_i,
    input  logic              branch_slot_end_i,
    output logic              id_valid_o,
    input  logic              id_ready_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0] ins_o,
    output logic [ADDR_W-1:0] next_pc_o,
    output logic              next_taken_o,
    output logic              branch_slot_end_o,
    output logic [CNT_W-1:0]  count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned EW    = entry_width(ADDR_W, INST_W);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic          flush;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          consumed;
    logic          mem_push;
    logic          mem_pop;
    logic [EW-1:0] wdata;
    logic [EW-1:0] rdata;
    logic [EW-1:0] head;

    assign flush = flush_i | branch_redirect_i;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign wdata = {pc_i, ins_i, next_pc_i, next_taken_i, branch_slot_end_i};

    // Fetch-side ready depends on occupancy only, never on the decoder
    assign if_ready_o = !full;
    assign push       = if_valid_i && if_ready_o;

`ifdef IF_ID_QUEUE_BYPASS_EN
    logic bypass;
    // Empty queue forwards the fetch entry straight to decode; taken this cycle means never stored
    assign bypass     = empty && if_valid_i;
    assign consumed   = bypass && id_ready_i;
    assign head       = bypass ? wdata : rdata;
    assign id_valid_o = !empty || bypass;
`else
    assign consumed   = 1'b0;
    assign head       = rdata;
    assign id_valid_o = !empty;
`endif

    assign pop      = id_valid_o && id_ready_i;
    assign mem_push = push && !consumed;
    assign mem_pop  = pop && !consumed;

    // Head fields; pc/next_pc/next_taken stay stale when empty, ins and marker are gated
    assign pc_o              = head[EW-1 -: ADDR_W];
    assign ins_o             = id_valid_o ? head[EW-ADDR_W-1 -: INST_W] : NOP_VAL;
    assign next_pc_o         = head[ADDR_W+1 -: ADDR_W];
    assign next_taken_o      = head[1];
    assign branch_slot_end_o = id_valid_o && head[0];
    assign count_o           = count_q;

    if_id_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (mem_push && !flush),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    // Next pointers and occupancy: flush clears everything and discards this cycle's push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (mem_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (mem_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({mem_push, mem_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifndef SYNTHESIS
    // Occupancy is bounded and storage is never read out while empty
    a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i) count_q <= CNT_W'(DEPTH))
        else $error("if_id_queue: count exceeds DEPTH");
    a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i) !(mem_pop && empty))
        else $error("if_id_queue: pop while empty");
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue (DEPTH=4): vector table plus scoreboard of queued entries.
// Honours IF_ID_QUEUE_BYPASS_EN when the build defines it.
module tb_if_id_queue;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_i, flush_i, branch_redirect_i;
    logic        if_valid_i, if_ready_o;
    logic [31:0] pc_i, ins_i, next_pc_i;
    logic        next_taken_i, branch_slot_end_i;
    logic        id_valid_o, id_ready_i;
    logic [31:0] pc_o, ins_o, next_pc_o;
    logic        next_taken_o, branch_slot_end_o;
    logic [2:0]  count_o;

    if_id_queue #(.DEPTH(DEPTH)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .flush_i           (flush_i),
        .branch_redirect_i (branch_redirect_i),
        .if_valid_i        (if_valid_i),
        .if_ready_o        (if_ready_o),
        .pc_i              (pc_i),
        .ins_i             (ins_i),
        .next_pc_i         (next_pc_i),
        .next_taken_i      (next_taken_i),
        .branch_slot_end_i (branch_slot_end_i),
        .id_valid_o        (id_valid_o),
        .id_ready_i        (id_ready_i),
        .pc_o              (pc_o),
        .ins_o             (ins_o),
        .next_pc_o         (next_pc_o),
        .next_taken_o      (next_taken_o),
        .branch_slot_end_o (branch_slot_end_o),
        .count_o           (count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] npc;
        logic        tk;
        logic        bse;
    } ent_t;

    // One cycle of stimulus and the outputs expected before the following edge
    typedef struct {
        logic        rst, flush, redir, ifv, idr;
        logic [31:0] pc, ins;
        int          cnt;
        logic        vld, rdy;
    } vec_t;

    ent_t sb[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic ent_t mk_ent(input logic [31:0] pc, input logic [31:0] ins);
        ent_t e;
        e.pc  = pc;
        e.ins = ins;
        e.npc = pc + 32'h8;
        e.tk  = pc[3];
        e.bse = pc[2];
        return e;
    endfunction

    function automatic vec_t mk_vec(input logic rst, input logic flush, input logic redir,
                                    input logic ifv, input logic idr, input logic [31:0] pc,
                                    input int cnt, input logic vld, input logic rdy);
        vec_t v;
        v.rst = rst; v.flush = flush; v.redir = redir; v.ifv = ifv; v.idr = idr;
        v.pc = pc; v.ins = {16'hC0DE, pc[15:0]};
        v.cnt = cnt; v.vld = vld; v.rdy = rdy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Drive one vector, check outputs mid-cycle, then advance the scoreboard across the edge
    task automatic run_cycle(input vec_t v);
        ent_t e, he;
        logic vld_e, byp;
        e = mk_ent(v.pc, v.ins);
        rst_i = v.rst; flush_i = v.flush; branch_redirect_i = v.redir;
        if_valid_i = v.ifv; id_ready_i = v.idr;
        pc_i = e.pc; ins_i = e.ins; next_pc_i = e.npc;
        next_taken_i = e.tk; branch_slot_end_i = e.bse;
        vld_e = v.vld;
        byp   = 1'b0;
`ifdef IF_ID_QUEUE_BYPASS_EN
        if (v.cnt == 0 && v.ifv) begin
            vld_e = 1'b1;
            byp   = 1'b1;
        end
`endif
        @(negedge clk_i);
        chk("count_o", 32'(count_o), 32'(v.cnt));
        chk("id_valid_o", 32'(id_valid_o), 32'(vld_e));
        chk("if_ready_o", 32'(if_ready_o), 32'(v.rdy));
        if (vld_e) begin
            if (byp) begin
                he = e;
            end else if (sb.size() == 0) begin
                he = mk_ent(32'hDEAD_BEEF, 32'hDEAD_BEEF);
                checks++;
                errors++;
                $display("FAIL head_scoreboard got valid head expected an empty queue at %0t", $time);
            end else begin
                he = sb[0];
            end
            chk("head_pc", pc_o, he.pc);
            chk("head_ins", ins_o, he.ins);
            chk("head_next_pc", next_pc_o, he.npc);
            chk("head_taken", 32'(next_taken_o), 32'(he.tk));
            chk("head_bse", 32'(branch_slot_end_o), 32'(he.bse));
        end else begin
            chk("empty_ins_nop", ins_o, NOP);
            chk("empty_bse", 32'(branch_slot_end_o), 32'd0);
        end
        if (v.rst || v.flush || v.redir) begin
            sb.delete();
        end else if (byp) begin
            if (!v.idr) sb.push_back(e);
        end else begin
            if (vld_e && v.idr && sb.size() > 0) void'(sb.pop_front());
            if (v.ifv && v.rdy) sb.push_back(e);
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // rst flush redir ifv idr pc cnt vld rdy
        vecs.push_back(mk_vec(0,0,0,0,0,32'h0,   0,0,1));   // reset state
        vecs.push_back(mk_vec(0,0,0,1,0,32'h100, 0,0,1));   // in-order fill while decode stalled
        vecs.push_back(mk_vec(0,0,0,1,0,32'h104, 1,1,1));
        vecs.push_back(mk_vec(0,0,0,1,0,32'h108, 2,1,1));
        vecs.push_back(mk_vec(0,0,0,0,1,32'h0,   3,1,1));   // drain 3,2,1,0
        vecs.push_back(mk_vec(0,0,0,0,1,32'h0,   2,1,1));
        vecs.push_back(mk_vec(0,0,0,0,1,32'h0,   1,1,1));
        vecs.push_back(mk_vec(0,0,0,0,1,32'h0,   0,0,1));
        vecs.push_back(mk_vec(0,0,0,1,0,32'h200, 0,0,1));   // fill to full
        vecs.push_back(mk_vec(0,0,0,1,0,32'h204, 1,1,1));
        vecs.push_back(mk_vec(0,0,0,1,0,32'h208, 2,1,1));
        vecs.push_back(mk_vec(0,0,0,1,0,32'h20C, 3,1,1));
        vecs.push_back(mk_vec(0,0,0,1,0,32'h210, 4,1,0));   // full refuses
        vecs.push_back(mk_vec(0,0,0,1,1,32'h214, 4,1,0));   // full refuses even while popping
        vecs.push_back(mk_vec(0,0,0,1,0,32'h218, 3,1,1));   // push across the wrap
        vecs.push_back(mk_vec(0,0,0,0,1,32'h0,   4,1,0));
        vecs.push_back(mk_vec(0,0,0,0,1,32'h0,   3,1,1));
        vecs.push_back(mk_vec(0,0,0,0,1,32'h0,   2,1,1));
        vecs.push_back(mk_vec(0,0,0,0,1,32'h0,   1,1,1));
        vecs.push_back(mk_vec(0,0,0,0,0,32'h0,   0,0,1));
        vecs.push_back(mk_vec(0,0,0,1,0,32'h300, 0,0,1));   // steady state with 2 resident
        vecs.push_back(mk_vec(0,0,0,1,0,32'h304, 1,1,1));
        for (int k = 0; k < 20; k++)
            vecs.push_back(mk_vec(0,0,0,1,1,32'h308 + 32'(4*k), 2,1,1));
        vecs.push_back(mk_vec(0,0,0,0,1,32'h0,   2,1,1));
        vecs.push_back(mk_vec(0,0,0,0,1,32'h0,   1,1,1));
        vecs.push_back(mk_vec(0,0,0,0,0,32'h0,   0,0,1));
        vecs.push_back(mk_vec(0,0,0,1,0,32'h500, 0,0,1));   // redirect with 3 resident and a push
        vecs.push_back(mk_vec(0,0,0,1,0,32'h504, 1,1,1));
        vecs.push_back(mk_vec(0,0,0,1,0,32'h508, 2,1,1));
        vecs.push_back(mk_vec(0,0,1,1,0,32'h50C, 3,1,1));
        vecs.push_back(mk_vec(0,0,0,0,0,32'h0,   0,0,1));
        vecs.push_back(mk_vec(0,0,0,1,0,32'h600, 0,0,1));   // flush with a push and a pop
        vecs.push_back(mk_vec(0,0,0,1,0,32'h604, 1,1,1));
        vecs.push_back(mk_vec(0,0,0,1,0,32'h608, 2,1,1));
        vecs.push_back(mk_vec(0,1,0,1,1,32'h60C, 3,1,1));
        vecs.push_back(mk_vec(0,0,0,0,0,32'h0,   0,0,1));
        vecs.push_back(mk_vec(0,0,0,1,0,32'h700, 0,0,1));   // reset together with flush
        vecs.push_back(mk_vec(0,0,0,1,0,32'h704, 1,1,1));
        vecs.push_back(mk_vec(0,0,0,1,0,32'h708, 2,1,1));
        vecs.push_back(mk_vec(1,1,0,1,1,32'h70C, 3,1,1));
        vecs.push_back(mk_vec(0,0,0,0,0,32'h0,   0,0,1));

        rst_i = 1'b1; flush_i = 1'b0; branch_redirect_i = 1'b0;
        if_valid_i = 1'b0; id_ready_i = 1'b0;
        pc_i = '0; ins_i = '0; next_pc_i = '0; next_taken_i = 1'b0; branch_slot_end_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;

        foreach (vecs[i]) run_cycle(vecs[i]);

        // Latency through an empty queue with decode ready
        run_cycle(mk_vec(0,0,0,1,1,32'h400, 0,0,1));
`ifdef IF_ID_QUEUE_BYPASS_EN
        run_cycle(mk_vec(0,0,0,0,1,32'h0,   0,0,1));
`else
        run_cycle(mk_vec(0,0,0,0,1,32'h0,   1,1,1));
        run_cycle(mk_vec(0,0,0,0,1,32'h0,   0,0,1));
`endif

        // Bypass with decode stalled still stores the entry
        run_cycle(mk_vec(0,0,0,1,0,32'h440, 0,0,1));
        run_cycle(mk_vec(0,0,0,0,1,32'h0,   1,1,1));
        run_cycle(mk_vec(0,0,0,0,0,32'h0,   0,0,1));

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain got %0d leftover entries expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
